// File: rtl/intr_gw_pkg.sv
// rtl/intr_gw_pkg.sv - shared types and constants for the interrupt gateway/arbiter
package intr_gw_pkg;

    typedef enum logic [1:0] {
        GwIdle      = 2'd0,
        GwPending   = 2'd1,
        GwInService = 2'd2
    } gw_state_e;

    localparam int MaxSrc   = 31;
    localparam int MissCntW = 8;

endpackage

// File: rtl/intr_gw_prio_tree.sv
// rtl/intr_gw_prio_tree.sv - combinational max-priority selector, ties to lowest ID
module intr_gw_prio_tree #(
    parameter int NumSrc = 4,
    parameter int PrioW  = 2,
    parameter int IdW    = $clog2(NumSrc + 1)
) (
    input  logic [NumSrc-1:0]       cand_i,
    input  logic [NumSrc*PrioW-1:0] prio_i,
    output logic [IdW-1:0]          win_id_o,
    output logic [PrioW-1:0]        win_prio_o
);

    // Scanning from the highest index down with >= lets a lower ID displace an equal-priority winner.
    always_comb begin
        win_id_o   = '0;
        win_prio_o = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (cand_i[i] && (win_id_o == '0 || prio_i[i*PrioW +: PrioW] >= win_prio_o)) begin
                win_id_o   = IdW'(i + 1);
                win_prio_o = prio_i[i*PrioW +: PrioW];
            end
        end
    end

endmodule

// File: rtl/intr_gateway_arb.sv
// rtl/intr_gateway_arb.sv - per-source interrupt gateways with registered target arbitration
// Optional dropped-edge counters are built when INTR_GW_MISS_CNT_EN is defined.
module intr_gateway_arb
    import intr_gw_pkg::*;
#(
    parameter int  NumSrc = 4,
    parameter int  PrioW  = 2,
    localparam int IdW    = $clog2(NumSrc + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumSrc-1:0]          intr_src_i,
    input  logic [NumSrc-1:0]          le_i,
    input  logic [NumSrc-1:0]          ie_i,
    input  logic [NumSrc*PrioW-1:0]    prio_i,
    input  logic [PrioW-1:0]           threshold_i,
    input  logic                       claim_i,
    input  logic                       complete_i,
    input  logic [IdW-1:0]             complete_id_i,
`ifdef INTR_GW_MISS_CNT_EN
    input  logic [NumSrc-1:0]          miss_clr_i,
    output logic [NumSrc*MissCntW-1:0] miss_cnt_o,
`endif
    output logic                       irq_o,
    output logic [IdW-1:0]             irq_id_o
);

    if (NumSrc < 1 || NumSrc > MaxSrc) begin : g_bad_cfg
        $error("intr_gateway_arb: NumSrc must be within 1..31");
    end

    gw_state_e         state_q [NumSrc];
    logic [NumSrc-1:0] src_q;
    logic [NumSrc-1:0] req;
    logic [NumSrc-1:0] pending;
    logic [NumSrc-1:0] in_service;
    logic [NumSrc-1:0] claim_hit;
    logic [NumSrc-1:0] complete_hit;
    logic [NumSrc-1:0] cand;
    logic [IdW-1:0]    win_id;
    logic [PrioW-1:0]  win_prio;

    assign req = intr_src_i & ~(le_i & src_q);

    // The source being claimed is masked here so the next registered result never re-presents it.
    always_comb begin
        pending      = '0;
        in_service   = '0;
        claim_hit    = '0;
        complete_hit = '0;
        cand         = '0;
        for (int i = 0; i < NumSrc; i++) begin
            pending[i]      = (state_q[i] == GwPending);
            in_service[i]   = (state_q[i] == GwInService);
            claim_hit[i]    = claim_i && pending[i] && (irq_id_o == IdW'(i + 1));
            complete_hit[i] = complete_i && in_service[i] && (complete_id_i == IdW'(i + 1));
            cand[i]         = pending[i] && !claim_hit[i] && ie_i[i]
                              && (prio_i[i*PrioW +: PrioW] > threshold_i);
        end
    end

    intr_gw_prio_tree #(
        .NumSrc (NumSrc),
        .PrioW  (PrioW),
        .IdW    (IdW)
    ) u_prio_tree (
        .cand_i     (cand),
        .prio_i     (prio_i),
        .win_id_o   (win_id),
        .win_prio_o (win_prio)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= '0;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
            for (int i = 0; i < NumSrc; i++) begin
                state_q[i] <= GwIdle;
            end
        end else begin
            src_q    <= intr_src_i;
            irq_id_o <= win_id;
            // Every candidate clears the threshold, so this is equivalent to win_id != 0.
            irq_o    <= (win_id != '0) && (win_prio > threshold_i);
            for (int i = 0; i < NumSrc; i++) begin
                case (state_q[i])
                    GwIdle:      if (req[i])          state_q[i] <= GwPending;
                    GwPending:   if (claim_hit[i])    state_q[i] <= GwInService;
                    GwInService: if (complete_hit[i]) state_q[i] <= GwIdle;
                    default:                          state_q[i] <= GwIdle;
                endcase
            end
        end
    end

`ifdef INTR_GW_MISS_CNT_EN
    logic [NumSrc-1:0]   drop;
    logic [MissCntW-1:0] miss_cnt_q [NumSrc];

    assign drop = le_i & req & (pending | in_service);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSrc; i++) begin
                miss_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSrc; i++) begin
                if (miss_clr_i[i]) begin
                    miss_cnt_q[i] <= '0;
                end else if (drop[i] && miss_cnt_q[i] != '1) begin
                    miss_cnt_q[i] <= miss_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        miss_cnt_o = '0;
        for (int i = 0; i < NumSrc; i++) begin
            miss_cnt_o[i*MissCntW +: MissCntW] = miss_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_intr_gateway_arb.sv
// tb/tb_intr_gateway_arb.sv - randomized bench for intr_gateway_arb against a behavioural model
module tb_intr_gateway_arb;

    localparam int NUM = 4;
    localparam int PW  = 2;
    localparam int IW  = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NUM-1:0]  intr_src_i;
    logic [NUM-1:0]  le_i;
    logic [NUM-1:0]  ie_i;
    logic [NUM*PW-1:0] prio_i;
    logic [PW-1:0]   threshold_i;
    logic            claim_i;
    logic            complete_i;
    logic [IW-1:0]   complete_id_i;
    logic            irq_o;
    logic [IW-1:0]   irq_id_o;
`ifdef INTR_GW_MISS_CNT_EN
    logic [NUM-1:0]   miss_clr_i;
    logic [NUM*8-1:0] miss_cnt_o;
    int               m_miss [NUM];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per source: 0 = idle, 1 = waiting for claim, 2 = claimed and awaiting completion.
    int             m_st [NUM];
    logic [NUM-1:0] m_prev;
    int             m_id;

    always #5 clk_i = ~clk_i;

    intr_gateway_arb #(
        .NumSrc (NUM),
        .PrioW  (PW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .intr_src_i    (intr_src_i),
        .le_i          (le_i),
        .ie_i          (ie_i),
        .prio_i        (prio_i),
        .threshold_i   (threshold_i),
        .claim_i       (claim_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
`ifdef INTR_GW_MISS_CNT_EN
        .miss_clr_i    (miss_clr_i),
        .miss_cnt_o    (miss_cnt_o),
`endif
        .irq_o         (irq_o),
        .irq_id_o      (irq_id_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_st[i] = 0;
`ifdef INTR_GW_MISS_CNT_EN
            m_miss[i] = 0;
`endif
        end
        m_prev = '0;
        m_id   = 0;
    endtask

    // Apply one clock of the gateway rules to the model using the inputs held across the edge.
    task automatic model_step();
        int claimed;
        int best_id;
        int best_p;
        int p;
        bit is_req;
        claimed = -1;
        best_id = 0;
        best_p  = -1;
        if (claim_i && m_id != 0 && m_st[m_id-1] == 1) claimed = m_id - 1;
        for (int i = 0; i < NUM; i++) begin
            p = int'(prio_i[i*PW +: PW]);
            if (m_st[i] == 1 && i != claimed && ie_i[i] && p > int'(threshold_i) && p > best_p) begin
                best_p  = p;
                best_id = i + 1;
            end
        end
        for (int i = 0; i < NUM; i++) begin
            is_req = intr_src_i[i] && !(le_i[i] && m_prev[i]);
`ifdef INTR_GW_MISS_CNT_EN
            if (miss_clr_i[i]) m_miss[i] = 0;
            else if (le_i[i] && is_req && m_st[i] != 0 && m_miss[i] < 255) m_miss[i]++;
`endif
            if (m_st[i] == 0 && is_req) m_st[i] = 1;
            else if (m_st[i] == 1 && i == claimed) m_st[i] = 2;
            else if (m_st[i] == 2 && complete_i && int'(complete_id_i) == i + 1) m_st[i] = 0;
        end
        m_id   = best_id;
        m_prev = intr_src_i;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_step();
        #1;
        check_val("irq", 32'(irq_o), 32'(m_id != 0));
        check_val("irq_id", 32'(irq_id_o), 32'(m_id));
`ifdef INTR_GW_MISS_CNT_EN
        for (int i = 0; i < NUM; i++) check_val("miss_cnt", 32'(miss_cnt_o[i*8 +: 8]), 32'(m_miss[i]));
`endif
        @(negedge clk_i);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NUM; i++) begin
            if ($urandom_range(0, 3) == 0) intr_src_i[i] = ~intr_src_i[i];
`ifdef INTR_GW_MISS_CNT_EN
            miss_clr_i[i] = ($urandom_range(0, 63) == 0);
`endif
        end
        claim_i       = ($urandom_range(0, 2) == 0);
        complete_i    = ($urandom_range(0, 2) == 0);
        complete_id_i = IW'($urandom_range(0, 7));
    endtask

    // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic mid_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("async_rst_irq", 32'(irq_o), 32'd0);
        check_val("async_rst_id", 32'(irq_id_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        intr_src_i    = '0;
        le_i          = '0;
        ie_i          = '0;
        prio_i        = '0;
        threshold_i   = '0;
        claim_i       = 1'b0;
        complete_i    = 1'b0;
        complete_id_i = '0;
`ifdef INTR_GW_MISS_CNT_EN
        miss_clr_i    = '0;
`endif
        repeat (2) @(negedge clk_i);
        check_val("reset_irq", 32'(irq_o), 32'd0);
        check_val("reset_id", 32'(irq_id_o), 32'd0);
        model_reset();
        rst_ni = 1'b1;

        for (int blk = 0; blk < 40; blk++) begin
            le_i        = NUM'($urandom);
            prio_i      = (NUM*PW)'($urandom);
            threshold_i = PW'($urandom_range(0, 2));
            for (int c = 0; c < 50; c++) begin
                if (c % 10 == 0) ie_i = NUM'($urandom | $urandom);
                if (c % 17 == 0) threshold_i = PW'($urandom_range(0, 2));
                rand_inputs();
                step();
            end
            if (blk % 10 == 9) mid_reset();
        end

        // Directed: level source 2 claimed, source 1 presenting, then reset mid-service.
        mid_reset();
        le_i        = '0;
        ie_i        = '1;
        prio_i      = '1;
        threshold_i = '0;
        claim_i     = 1'b0;
        complete_i  = 1'b0;
        intr_src_i  = 4'b0010;
        repeat (3) step();
        check_val("dir_id2", 32'(irq_id_o), 32'd2);
        claim_i = 1'b1;
        step();
        claim_i    = 1'b0;
        intr_src_i = 4'b0011;
        repeat (2) step();
        check_val("dir_pre_rst_irq", 32'(irq_o), 32'd1);
        mid_reset();
        repeat (2) step();
        check_val("dir_repend_irq", 32'(irq_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_gateway_arb.md
Name: intr_gateway_arb

Overview:
- Interrupt gateway and target arbiter downstream of the timer and other peripheral interrupt outputs, e.g. intr_timer_expired_0_0_o.
- Captures each raw source into a per-source pending/in-service gateway.
- Selects the highest-priority enabled pending source above a threshold.
- Presents it to the hart as a registered irq line plus ID, with a claim/complete handshake.

Parameters:
- NumSrc, 4, number of interrupt sources (1..31); source ID n maps to bit n-1; ID 0 = none.
- PrioW, 2, priority width; priority 0 = never interrupts.
- IdW, $clog2(NumSrc+1), ID width (derived, not overridable).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- intr_src_i  input  NumSrc  raw interrupt lines, synchronous to clk_i
- le_i  input  NumSrc  per-source mode: 1 = rising-edge, 0 = level
- ie_i  input  NumSrc  per-source enable
- prio_i  input  NumSrc*PrioW  packed priorities; source n at [n*PrioW-1 -: PrioW]
- threshold_i  input  PrioW  only priority > threshold interrupts
- claim_i  input  1  one-cycle claim strobe; claims current irq_id_o
- complete_i  input  1  one-cycle complete strobe
- complete_id_i  input  IdW  ID being completed
- irq_o  output  1  interrupt request to hart
- irq_id_o  output  IdW  ID of the winning source; 0 when irq_o = 0

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All gateways IDLE.
  - Edge-detect register src_q = 0.
  - irq_o = 0, irq_id_o = 0.
- Request per source: level mode = intr_src_i; edge mode = intr_src_i & ~src_q. src_q updates every cycle.
- Gateway FSM per source:
  - IDLE -> PENDING on request.
  - PENDING -> IN_SERVICE on claim_i with irq_id_o == this ID.
  - IN_SERVICE -> IDLE on complete_i with complete_id_i == this ID.
  - Edge mode: requests arriving in PENDING or IN_SERVICE are dropped.
  - Level mode: a line still high on return to IDLE re-pends on the next clock.
- Arbitration (combinational):
  - Candidates: PENDING & ie_i & prio > threshold_i.
  - Highest priority wins; ties go to the lowest ID.
  - Result registered into irq_id_o / irq_o (irq_o = id != 0).
- Latency: request at edge k -> PENDING at edge k+1 -> irq_o visible after edge k+2.
- Claim:
  - Moves the source out of PENDING immediately.
  - irq_id_o re-evaluates and updates at the next edge (the claimed ID is not re-presented).
  - claim_i with irq_id_o == 0 has no effect.
- Complete:
  - complete_id_i of 0, out of range, or not IN_SERVICE is ignored.
- Simultaneous events:
  - Claim and complete in the same cycle (different IDs): both take effect.
  - Same-cycle claim of source A and request on source B: both take effect.
- Disabling:
  - Clearing ie_i while PENDING keeps the source pending but removes it from arbitration.
  - Re-enabling re-presents the source without a new request.
- Priority and threshold changes take effect on the next registered arbitration result.

Optional Feature:
- INTR_GW_MISS_CNT_EN defined:
  - Adds output miss_cnt_o, NumSrc*8 bits.
  - Per-source 8-bit saturating counter, incremented when an edge-mode request is dropped (PENDING or IN_SERVICE).
  - Counters reset to 0 and hold at 255.
  - Adds input miss_clr_i, NumSrc bits; a set bit clears that counter, with clear taking precedence over increment.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package intr_gw_pkg holds:
  - gw_state_e enum {GwIdle, GwPending, GwInService}, 2-bit
  - MaxSrc = 31 constant
  - MissCntW = 8 constant
- Sub-module intr_gw_prio_tree: combinational max-priority/lowest-ID selector over NumSrc candidates, returning winner ID and priority.

Test Plan:
- Level source 1, prio 3, threshold 0, ie = 1: raise at cycle 0 -> irq_o = 1, irq_id_o = 1 at cycle 2. Claim -> irq_o = 0 at the next edge. Complete ID 1 with line still high -> re-asserts 2 cycles later.
- Sources 2 (prio 2) and 3 (prio 2) plus 1 (prio 1) pending together: irq_id_o = 2. After claiming 2: irq_id_o = 3. After claiming 3: irq_id_o = 1.
- Edge source 4, prio 1, threshold 1: pulse -> stays PENDING, irq_o = 0. Set threshold 0 -> irq_id_o = 4 one cycle later.
- Edge source 1: a second pulse during IN_SERVICE is dropped; after complete, irq_o stays 0. With INTR_GW_MISS_CNT_EN: miss_cnt_o[7:0] = 1; 300 drops -> 255.
- Claim 2 and complete 1 in the same cycle -> both states update. Complete ID 5 or ID 0 -> ignored, no state change.
- Assert rst_ni mid-service (source 2 IN_SERVICE) -> irq_o = 0 and irq_id_o = 0 immediately. After release, a level source still high re-pends within 2 cycles.
